conv_stream_driver: RTL and testbench

Host-side transmitter/receiver for the 7x7-IFM / 3x3-weight convolution engine. Holds a 49-word IFM image and 9 weights loaded over a simple write port, streams them to the engine using the engine's `in_valid`/`weight_valid` serial protocol, then captures the 25-word `out_valid`/`Out_OFM` result burst into a readable result buffer. It sits between the test/host controller and the convolution engine and is the opposite end of the engine's I/O protocol.

---
 rtl/conv_stream_driver_if.sv | 24 ++
 rtl/conv_stream_driver.sv | 187 ++++++++++++++++++
 tb/tb_conv_stream_driver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_driver_if.sv
// rtl/conv_stream_driver_if.sv - engine-side stream bundle between driver and convolution engine
interface conv_stream_driver_if #(
    parameter int IFM_W = 16,
    parameter int OFM_W = 36
);
    logic             in_valid;
    logic             weight_valid;
    logic [IFM_W-1:0] In_IFM_1;
    logic [IFM_W-1:0] In_Weight_1;
    logic             out_valid;
    logic [OFM_W-1:0] Out_OFM;

    // driver side: sends IFM/weight beats, receives result beats
    modport master (
        output in_valid, weight_valid, In_IFM_1, In_Weight_1,
        input  out_valid, Out_OFM
    );

    // engine side
    modport slave (
        input  in_valid, weight_valid, In_IFM_1, In_Weight_1,
        output out_valid, Out_OFM
    );
endinterface

// File: rtl/conv_stream_driver.sv
// rtl/conv_stream_driver.sv - host-side frame loader, streamer and result capture for the conv engine
module conv_stream_driver #(
    parameter int IFM_W   = 16,
    parameter int OFM_W   = 36,
    parameter int IFM_N   = 49,
    parameter int WGT_N   = 9,
    parameter int OFM_N   = 25,
    parameter int TIMEOUT = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [5:0]       wr_addr,
    input  logic [IFM_W-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [4:0]       rd_addr,
    output logic [OFM_W-1:0] rd_data,
    conv_stream_driver_if.master eng
);

    localparam logic [5:0] IFM_LIM   = 6'(IFM_N);
    localparam logic [5:0] WGT_LIM   = 6'(WGT_N);
    localparam logic [5:0] BEAT_LAST = 6'(IFM_N - 1);
    localparam logic [4:0] RES_LIM   = 5'(OFM_N);
    localparam logic [5:0] TMO       = 6'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

    state_t           state;
    logic [IFM_W-1:0] ifm [IFM_N];
    logic [IFM_W-1:0] wgt [WGT_N];
    logic [OFM_W-1:0] res [OFM_N];

    logic [5:0]       beat;
    logic [5:0]       beat_nxt;
    logic [4:0]       index;
    logic [5:0]       timer;
    logic             in_valid_q;
    logic             weight_valid_q;
    logic [IFM_W-1:0] ifm_q;
    logic [IFM_W-1:0] wgt_q;
    logic             res_we;
    logic [4:0]       res_wa;

    assign eng.in_valid     = in_valid_q;
    assign eng.weight_valid = weight_valid_q;
    assign eng.In_IFM_1     = ifm_q;
    assign eng.In_Weight_1  = wgt_q;

    // beat counter tracks the beat currently on the bus; the first SEND cycle puts beat 0 up
    always_comb begin
        beat_nxt = in_valid_q ? beat + 6'd1 : 6'd0;
    end

    // result capture: first word lands in WAIT at res[0], the rest in RECV until 25 are held
    always_comb begin
        res_we = 1'b0;
        res_wa = index;
        if (state == S_WAIT && eng.out_valid) begin
            res_we = 1'b1;
            res_wa = 5'd0;
        end else if (state == S_RECV && eng.out_valid && index < RES_LIM) begin
            res_we = 1'b1;
        end
    end

    // host write port into the IFM and weight buffers, idle only, out-of-range addresses dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IFM_N; i++) ifm[i] <= '0;
            for (int i = 0; i < WGT_N; i++) wgt[i] <= '0;
        end else if (wr_en && state == S_IDLE) begin
            if (!wr_sel && wr_addr < IFM_LIM) begin
                ifm[wr_addr] <= wr_data;
            end else if (wr_sel && wr_addr < WGT_LIM) begin
                wgt[wr_addr[3:0]] <= wr_data;
            end
        end
    end

    // result buffer; words not written by a frame keep their old values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OFM_N; i++) res[i] <= '0;
        end else if (res_we) begin
            res[res_wa] <= eng.Out_OFM;
        end
    end

    // registered read port, addresses past the buffer read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= (rd_addr < RES_LIM) ? res[rd_addr] : '0;
        end
    end

    // frame sequencer: send 49 beats, wait for the result burst, collect it, pulse done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            beat           <= '0;
            index          <= '0;
            timer          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            in_valid_q     <= 1'b0;
            weight_valid_q <= 1'b0;
            ifm_q          <= '0;
            wgt_q          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SEND;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        beat  <= '0;
                        index <= '0;
                    end
                end
                S_SEND: begin
                    if (in_valid_q && beat == BEAT_LAST) begin
                        in_valid_q     <= 1'b0;
                        weight_valid_q <= 1'b0;
                        ifm_q          <= '0;
                        wgt_q          <= '0;
                        timer          <= '0;
                        state          <= S_WAIT;
                    end else begin
                        beat       <= beat_nxt;
                        in_valid_q <= 1'b1;
                        ifm_q      <= ifm[beat_nxt];
                        if (beat_nxt < WGT_LIM) begin
                            weight_valid_q <= 1'b1;
                            wgt_q          <= wgt[beat_nxt[3:0]];
                        end else begin
                            weight_valid_q <= 1'b0;
                            wgt_q          <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (eng.out_valid) begin
                        index <= 5'd1;
                        state <= S_RECV;
                    end else if (timer == TMO) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        timer <= timer + 6'd1;
                    end
                end
                S_RECV: begin
                    if (index == RES_LIM) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (eng.out_valid) begin
                        index <= index + 5'd1;
                    end else begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_driver.sv
// tb/tb_conv_stream_driver.sv - scoreboard bench for conv_stream_driver
module tb_conv_stream_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        wr_sel;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  rd_addr;
    logic [35:0] rd_data;

    conv_stream_driver_if #(.IFM_W(16), .OFM_W(36)) eng ();

    conv_stream_driver dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .eng     (eng)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ifm_m [49];
    logic [15:0] wgt_m [9];
    logic [35:0] res_m [25];
    logic [33:0] sb_beat [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic sel, input logic [5:0] addr, input logic [15:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        if (!sel && addr < 6'd49) ifm_m[addr] = data;
        if (sel && addr < 6'd9) wgt_m[addr] = data;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 25; i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            check($sformatf("%s_res%0d", tag, i), rd_data, res_m[i]);
        end
        rd_addr = 5'd30;
        @(negedge clk);
        check($sformatf("%s_rd30", tag), rd_data, 0);
        rd_addr = 5'd0;
    endtask

    task automatic run_frame(input int n_ret, input int base, input bit disturb, input bit exp_err);
        int cnt;
        logic [33:0] exp_b;
        logic [33:0] got_b;
        for (int j = 0; j < 49; j++) begin
            if (j < 9) exp_b = {1'b1, 1'b1, ifm_m[j], wgt_m[j]};
            else       exp_b = {1'b1, 1'b0, ifm_m[j], 16'h0};
            sb_beat.push_back(exp_b);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start", busy, 1);
        check("err_clear", err, 0);
        check("pre_beat", eng.in_valid, 0);
        @(negedge clk);
        for (int k = 0; k < 49; k++) begin
            wr_en = 1'b0; start = 1'b0;
            got_b = {eng.in_valid, eng.weight_valid, eng.In_IFM_1, eng.In_Weight_1};
            if (sb_beat.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                exp_b = sb_beat.pop_front();
                check($sformatf("beat%0d", k), got_b, exp_b);
            end
            if (disturb && k == 5) begin wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd40; wr_data = 16'hdead; end
            if (disturb && k == 6) begin wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 6'd2; wr_data = 16'hbeef; end
            if (disturb && k == 10) start = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0; start = 1'b0;
        check("fall", {eng.in_valid, eng.weight_valid, eng.In_IFM_1, eng.In_Weight_1}, 0);
        cnt = 0;
        if (n_ret == 0) begin
            while (!done && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            check("timeout_cycles", cnt, 64);
        end else begin
            @(negedge clk);
            @(negedge clk);
            for (int i = 0; i < n_ret; i++) begin
                eng.out_valid = 1'b1;
                eng.Out_OFM = 36'(base + i);
                res_m[i] = 36'(base + i);
                start = (disturb && i == 3);
                @(negedge clk);
            end
            eng.out_valid = 1'b0; eng.Out_OFM = '0; start = 1'b0;
            while (!done && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            check("done_lat", cnt, 1);
        end
        check("err_at_done", err, exp_err);
        check("busy_at_done", busy, 0);
        start = disturb;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("err_sticky", err, exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; rd_addr = '0; eng.out_valid = 1'b0; eng.Out_OFM = '0;
        for (int i = 0; i < 49; i++) ifm_m[i] = '0;
        for (int i = 0; i < 9; i++) wgt_m[i] = '0;
        for (int i = 0; i < 25; i++) res_m[i] = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outs", {busy, done, err, eng.in_valid, eng.weight_valid,
                             eng.In_IFM_1, eng.In_Weight_1, rd_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // frame 1: ramp image, unit weights, out-of-range writes, disturbances during the frame
        for (int k = 0; k < 49; k++) host_write(1'b0, 6'(k), 16'(k + 1));
        for (int k = 0; k < 9; k++) host_write(1'b1, 6'(k), 16'd1);
        host_write(1'b0, 6'd49, 16'h5a5a);
        host_write(1'b1, 6'd9, 16'h7777);
        run_frame(25, 100, 1'b1, 1'b0);
        read_all("f1");

        // frame 2: engine never answers
        run_frame(0, 0, 1'b0, 1'b1);
        read_all("f2");

        // frame 3: new data, burst stops after 10 words
        for (int k = 0; k < 49; k++) host_write(1'b0, 6'(k), 16'($urandom_range(0, 65535)));
        for (int k = 0; k < 9; k++) host_write(1'b1, 6'(k), 16'(3 * k + 7));
        run_frame(10, 500, 1'b0, 1'b1);
        read_all("f3");

        // reset at beat 20 of SEND
        rd_addr = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        repeat (20) @(negedge clk);
        check("pre_rst_valid", eng.in_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_outs", {busy, done, err, eng.in_valid, eng.weight_valid,
                           eng.In_IFM_1, eng.In_Weight_1, rd_data}, 0);
        for (int i = 0; i < 49; i++) ifm_m[i] = '0;
        for (int i = 0; i < 9; i++) wgt_m[i] = '0;
        for (int i = 0; i < 25; i++) res_m[i] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_all("rst");
        run_frame(0, 0, 1'b0, 1'b1);

        // fresh load after reset
        for (int k = 0; k < 49; k++) host_write(1'b0, 6'(k), 16'(1000 + 7 * k));
        for (int k = 0; k < 9; k++) host_write(1'b1, 6'(k), 16'(k + 20));
        run_frame(25, 1000, 1'b0, 1'b0);
        read_all("f5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
